// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen: raster timing for 1280x720@60 (720p).
// Two chained free-running counters (h_cnt/v_cnt). Their decode gives the
// combinational pixel request and coordinates for the colour stage.
// The registered sync/DE/frame_start outputs lag the counters by one cycle.
// This is the same one-cycle latency that the colour stage adds to pixel_data,
// so the colour, sync and DE outputs are mutually aligned.
module vga_timing_gen #(
  parameter logic [10:0] H_SYNC   = 11'd40,
  parameter logic [10:0] H_BACK   = 11'd220,
  parameter logic [10:0] H_DISP   = 11'd1280,
  parameter logic [10:0] H_FRONT  = 11'd110,
  parameter logic [10:0] H_TOTAL  = 11'd1650,
  parameter logic [10:0] V_SYNC   = 11'd5,
  parameter logic [10:0] V_BACK   = 11'd20,
  parameter logic [10:0] V_DISP   = 11'd720,
  parameter logic [10:0] V_FRONT  = 11'd5,
  parameter logic [10:0] V_TOTAL  = 11'd750,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic [5:0]  pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        data_req,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [5:0]  vga_rgb,
  output logic        frame_start
);

  // Active window bounds, inclusive on both ends.
  localparam logic [10:0] H_ACT_START = H_SYNC + H_BACK;
  localparam logic [10:0] H_ACT_END   = H_SYNC + H_BACK + H_DISP - 11'd1;
  localparam logic [10:0] V_ACT_START = V_SYNC + V_BACK;
  localparam logic [10:0] V_ACT_END   = V_SYNC + V_BACK + V_DISP - 11'd1;
  localparam logic [10:0] H_LAST      = H_TOTAL - 11'd1;
  localparam logic [10:0] V_LAST      = V_TOTAL - 11'd1;

  // An inconsistent porch/total set elaborates this marker block.
  // It makes the mistake visible in the hierarchy.
  if ((H_SYNC + H_BACK + H_DISP + H_FRONT) != H_TOTAL ||
      (V_SYNC + V_BACK + V_DISP + V_FRONT) != V_TOTAL) begin : g_total_mismatch
  end

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        de_q;
  logic        fs_q, fs_d;
  logic        h_win, v_win;
  logic        line_end;

  // Next counter values: h wraps every line; v steps (and wraps) only at line end.
  always_comb begin
    line_end = (h_cnt_q == H_LAST);
    h_cnt_d  = line_end ? 11'd0 : h_cnt_q + 11'd1;
    v_cnt_d  = v_cnt_q;
    if (line_end) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
    end
  end

  // Window decode and coordinates.
  // Coordinates are forced to 0 outside the window, so the subtraction never underflows visibly.
  always_comb begin
    h_win      = (h_cnt_q >= H_ACT_START) && (h_cnt_q <= H_ACT_END);
    v_win      = (v_cnt_q >= V_ACT_START) && (v_cnt_q <= V_ACT_END);
    data_req   = h_win && v_win;
    pixel_xpos = data_req ? (h_cnt_q - H_ACT_START) : 11'd0;
    pixel_ypos = data_req ? (v_cnt_q - V_ACT_START) : 11'd0;
  end

  // Sync and frame-marker decode from the current counts; these are registered below.
  always_comb begin
    hs_d = (h_cnt_q < H_SYNC) ? SYNC_POL : ~SYNC_POL;
    vs_d = (v_cnt_q < V_SYNC) ? SYNC_POL : ~SYNC_POL;
    fs_d = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
  end

  // Raster counters; reset restarts the frame at (0,0).
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt_q <= 11'd0;
      v_cnt_q <= 11'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Registered video controls, one cycle behind the counters to match pixel_data latency.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hs_q <= ~SYNC_POL;
      vs_q <= ~SYNC_POL;
      de_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= data_req;
      fs_q <= fs_d;
    end
  end

  // Colour is blanked outside DE whatever the colour stage drives.
  always_comb begin
    vga_hs      = hs_q;
    vga_vs      = vs_q;
    vga_de      = de_q;
    frame_start = fs_q;
    vga_rgb     = de_q ? pixel_data : 6'b0;
  end

endmodule
